// File: rtl/time_counter_bcd.sv
// BCD time-of-day counter driven by the divider's 1 Hz tick, with manual minute/hour setting.
// Optional 12 h display mapping and pm flag are enabled by defining FORMAT_12H_EN.
module time_counter_bcd #(
  parameter int unsigned INIT_HH = 0,
  parameter int unsigned INIT_MM = 0,
  parameter int unsigned INIT_SS = 0
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       run,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [3:0] hh_tens,
  output logic [3:0] hh_ones,
  output logic [3:0] mm_tens,
  output logic [3:0] mm_ones,
  output logic [3:0] ss_tens,
  output logic [3:0] ss_ones,
  output logic       sec_pulse,
  output logic       day_wrap,
  output logic       pm
);

  localparam logic [3:0] InitHT = 4'(INIT_HH / 10);
  localparam logic [3:0] InitHO = 4'(INIT_HH % 10);
  localparam logic [3:0] InitMT = 4'(INIT_MM / 10);
  localparam logic [3:0] InitMO = 4'(INIT_MM % 10);
  localparam logic [3:0] InitST = 4'(INIT_SS / 10);
  localparam logic [3:0] InitSO = 4'(INIT_SS % 10);

  // Increment a two-digit BCD value in 00..59; returns {tens, ones}.
  function automatic logic [7:0] inc_bcd60(input logic [3:0] t, input logic [3:0] o);
    if (o != 4'd9)      return {t, o + 4'd1};
    else if (t != 4'd5) return {t + 4'd1, 4'd0};
    else                return 8'h00;
  endfunction

  function automatic logic [7:0] inc_bcd24(input logic [3:0] t, input logic [3:0] o);
    if (t == 4'd2 && o == 4'd3) return 8'h00;
    else if (o == 4'd9)         return {t + 4'd1, 4'd0};
    else                        return {t, o + 4'd1};
  endfunction

  logic       r_tick_d, r_min_d, r_hour_d;
  logic [3:0] r_hh_t, r_hh_o, r_mm_t, r_mm_o, r_ss_t, r_ss_o;
  logic       r_sec_pulse, r_day_wrap;

  logic       w_tick_rise, w_min_rise, w_hour_rise;
  logic [3:0] w_hh_t, w_hh_o, w_mm_t, w_mm_o, w_ss_t, w_ss_o;
  logic       w_sec_pulse, w_day_wrap;
  logic       w_sec_carry, w_min_carry, w_hour_last;

  assign w_tick_rise = tick_in & ~r_tick_d;
  assign w_min_rise  = inc_min & ~r_min_d;
  assign w_hour_rise = inc_hour & ~r_hour_d;

  assign w_sec_carry = ({r_ss_t, r_ss_o} == 8'h59);
  assign w_min_carry = ({r_mm_t, r_mm_o} == 8'h59);
  assign w_hour_last = ({r_hh_t, r_hh_o} == 8'h23);

  always_comb begin
    w_hh_t      = r_hh_t;
    w_hh_o      = r_hh_o;
    w_mm_t      = r_mm_t;
    w_mm_o      = r_mm_o;
    w_ss_t      = r_ss_t;
    w_ss_o      = r_ss_o;
    w_sec_pulse = 1'b0;
    w_day_wrap  = 1'b0;
    if (set_mode) begin
      // Minute and hour edits are independent: no carry between them.
      if (w_min_rise) begin
        {w_mm_t, w_mm_o} = inc_bcd60(r_mm_t, r_mm_o);
        {w_ss_t, w_ss_o} = 8'h00;
      end
      if (w_hour_rise) begin
        {w_hh_t, w_hh_o} = inc_bcd24(r_hh_t, r_hh_o);
      end
    end else if (run && w_tick_rise) begin
      w_sec_pulse      = 1'b1;
      {w_ss_t, w_ss_o} = inc_bcd60(r_ss_t, r_ss_o);
      if (w_sec_carry) begin
        {w_mm_t, w_mm_o} = inc_bcd60(r_mm_t, r_mm_o);
        if (w_min_carry) begin
          {w_hh_t, w_hh_o} = inc_bcd24(r_hh_t, r_hh_o);
          w_day_wrap       = w_hour_last;
        end
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      // Edge registers start high so a level held through reset is not an edge.
      r_tick_d    <= 1'b1;
      r_min_d     <= 1'b1;
      r_hour_d    <= 1'b1;
      r_hh_t      <= InitHT;
      r_hh_o      <= InitHO;
      r_mm_t      <= InitMT;
      r_mm_o      <= InitMO;
      r_ss_t      <= InitST;
      r_ss_o      <= InitSO;
      r_sec_pulse <= 1'b0;
      r_day_wrap  <= 1'b0;
    end else begin
      r_tick_d    <= tick_in;
      r_min_d     <= inc_min;
      r_hour_d    <= inc_hour;
      r_hh_t      <= w_hh_t;
      r_hh_o      <= w_hh_o;
      r_mm_t      <= w_mm_t;
      r_mm_o      <= w_mm_o;
      r_ss_t      <= w_ss_t;
      r_ss_o      <= w_ss_o;
      r_sec_pulse <= w_sec_pulse;
      r_day_wrap  <= w_day_wrap;
    end
  end

`ifdef FORMAT_12H_EN
  // Map 24 h BCD to 12 h display digits; returns {pm, tens, ones}.
  function automatic logic [8:0] map_12h(input logic [3:0] t, input logic [3:0] o);
    int unsigned h;
    int unsigned h12;
    h = 32'(t) * 10 + 32'(o);
    if (h == 0)      h12 = 12;
    else if (h > 12) h12 = h - 12;
    else             h12 = h;
    return {(h >= 12), 4'(h12 / 10), 4'(h12 % 10)};
  endfunction

  localparam logic [8:0] InitMap = map_12h(InitHT, InitHO);

  logic [8:0] w_map;
  logic [3:0] r_hh_out_t, r_hh_out_o;
  logic       r_pm;

  assign w_map = map_12h(w_hh_t, w_hh_o);

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_hh_out_t <= InitMap[7:4];
      r_hh_out_o <= InitMap[3:0];
      r_pm       <= 1'b0;
    end else begin
      r_hh_out_t <= w_map[7:4];
      r_hh_out_o <= w_map[3:0];
      r_pm       <= w_map[8];
    end
  end

  assign hh_tens = r_hh_out_t;
  assign hh_ones = r_hh_out_o;
  assign pm      = r_pm;
`else
  assign hh_tens = r_hh_t;
  assign hh_ones = r_hh_o;
  assign pm      = 1'b0;
`endif

  assign mm_tens   = r_mm_t;
  assign mm_ones   = r_mm_o;
  assign ss_tens   = r_ss_t;
  assign ss_ones   = r_ss_o;
  assign sec_pulse = r_sec_pulse;
  assign day_wrap  = r_day_wrap;

endmodule

// File: doc/time_counter_bcd.md
# time_counter_bcd

Timekeeping stage fed by the frequency divider: counts seconds, minutes and hours in BCD from the divider's 1 Hz square wave and drives the six display digits. It also handles manual time setting. tick_in comes from the divider on the same clock_in, so the block detects the rising edge only; no synchronizer is needed.

## Interface
- INIT_HH, 0, hour loaded on reset (binary, 0–23)
- INIT_MM, 0, minute loaded on reset (binary, 0–59)
- INIT_SS, 0, second loaded on reset (binary, 0–59)
- clock_in  input  1  system clock; all state on its rising edge
- reset  input  1  synchronous, active-high reset
- tick_in  input  1  divider output; each 0→1 transition is one second
- run  input  1  count enable; ticks ignored while low
- set_mode  input  1  setting mode; seconds frozen, inc_* accepted
- inc_min  input  1  level; each rising edge adds one minute in setting mode
- inc_hour  input  1  level; each rising edge adds one hour in setting mode
- hh_tens, hh_ones, mm_tens, mm_ones, ss_tens, ss_ones  output  4 each  BCD digits, registered
- sec_pulse  output  1  one-cycle pulse per accepted second
- day_wrap  output  1  one-cycle pulse on 23:59:59→00:00:00
- pm  output  1  afternoon flag (see Configuration)

## Operation
- Edge detect: tick_d, min_d and hour_d hold last-cycle samples.
  - tick_rise = tick_in & ~tick_d.
  - min_rise and hour_rise are formed the same way.
- Reset:
  - Digits load the BCD of INIT_HH:INIT_MM:INIT_SS.
  - tick_d, min_d and hour_d load 1, so an input held high at reset release does not count.
  - sec_pulse, day_wrap and pm load 0.
- Counting, on tick_rise & run & ~set_mode:
  - ss_ones 9→0 carries to ss_tens; ss_tens 5→0 carries to minutes. Minutes follow the same rule and carry to hours.
  - Hours run 00..23. 23→00 only via the full carry chain, and then day_wrap=1 for that cycle.
  - sec_pulse=1 in the same cycle the digits update.
- Setting mode (set_mode=1):
  - tick_rise is ignored; sec_pulse and day_wrap stay 0.
  - min_rise: minutes +1, 59→00 with no carry to hours; seconds cleared to 00.
  - hour_rise: hours +1, 23→00; day_wrap not asserted.
  - Both in the same cycle: both applied independently.
- inc_min and inc_hour are ignored when set_mode=0. Edge registers still update, so holding a button across a mode change does not trigger an increment.
- run=0 with set_mode=0: everything holds, and ticks are lost (not queued).
- Internal state: hours held as 24 h BCD. The hh_* outputs go through the optional 12 h mapping before their output register.
- INIT_* out of range is illegal; behaviour is undefined and needs no check.

## Timing
- Latency: first clock edge that samples tick_in=1 after 0 → digits, sec_pulse and day_wrap change at that same edge. Visible one cycle after tick_in rises in the divider.
- Setting edits have the same 1-cycle latency from the sampled inc_* edge.
- Pulses are exactly one clock_in cycle wide. They are never back-to-back from one tick, because the divider's high phase is ≥1 cycle.
- Reset takes priority over every event in the same cycle.

## Configuration
- FORMAT_12H_EN defined:
  - hh_* show 12,01..11. Hours 0 and 12 show 12; 13–23 show minus 12.
  - pm=1 for internal hours 12–23. pm updates in the same cycle as hh_*.
- FORMAT_12H_EN undefined:
  - hh_* show 00..23 directly.
  - pm is tied to 0 and the mapping logic is absent.

## Test plan
- Reset with INIT 23:59:58, run=1, two tick_in rising edges → 23:59:59, then 00:00:00. day_wrap high exactly one cycle on the second edge; sec_pulse once per edge.
- tick_in held high through reset release → no count. The first real 0→1 gives 00:00:01 one cycle later.
- run=0, five ticks → digits unchanged, no sec_pulse. Then run=1 with one tick → +1 s only.
- set_mode=1 at 10:59:37, inc_min edge → 10:00:00 (no hour carry). inc_hour with inc_min in the same cycle → 11:01:00. Ticks during set_mode → no change.
- 12:xx hours under FORMAT_12H_EN: INIT 11:59:59 plus a tick → hh=12, pm=1. INIT 00:00:00 → hh=12, pm=0. Without the macro → hh=00, pm=0.
- Reset asserted mid-count at 05:06:07 → next cycle shows INIT values. sec_pulse and day_wrap are 0.
